// File: rtl/otter_ex_pkg.sv
// Shared types and constants for the OTTER execute stage.
package otter_ex_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_LUI  = 4'b1001,
        ALU_SRA  = 4'b1101
    } alu_fun_t;

endpackage

// File: rtl/otter_ex_alu.sv
// Purely combinational RV32I ALU; unused opcodes produce zero.
module otter_ex_alu
    import otter_ex_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      fun,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (alu_fun_t'(fun))
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = XLEN'($signed(a) < $signed(b));
            ALU_SLTU: result = XLEN'(a < b);
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = XLEN'($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_LUI:  result = a;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/otter_ex_unit.sv
// OTTER execute stage: ALU, branch address/condition generators and the EX/MEM result register.
// Define OTTER_JALR_LSB_CLEAR_EN to force bit 0 of the JALR target to zero.
module otter_ex_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    input  logic            FLUSH,
    input  logic [XLEN-1:0] SRC_A,
    input  logic [XLEN-1:0] SRC_B,
    input  logic [3:0]      ALU_FUN,
    input  logic [XLEN-1:0] RS1,
    input  logic [XLEN-1:0] RS2,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] I_TYPE,
    input  logic [XLEN-1:0] B_TYPE,
    input  logic [XLEN-1:0] J_TYPE,
    output logic [XLEN-1:0] RESULT,
    output logic            BR_EQ,
    output logic            BR_LT,
    output logic            BR_LTU,
    output logic [XLEN-1:0] JAL,
    output logic [XLEN-1:0] BRANCH,
    output logic [XLEN-1:0] JALR,
    output logic [XLEN-1:0] RESULT_Q,
    output logic [2:0]      FLAGS_Q
);

    logic [XLEN-1:0] jalr_sum;

    otter_ex_alu u_alu (
        .a      (SRC_A),
        .b      (SRC_B),
        .fun    (ALU_FUN),
        .result (RESULT)
    );

    // Branch condition generator
    assign BR_EQ  = (RS1 == RS2);
    assign BR_LT  = ($signed(RS1) < $signed(RS2));
    assign BR_LTU = (RS1 < RS2);

    // Branch address generator; immediates arrive pre-shifted and sign-extended
    assign JAL      = PC + J_TYPE;
    assign BRANCH   = PC + B_TYPE;
    assign jalr_sum = RS1 + I_TYPE;

`ifdef OTTER_JALR_LSB_CLEAR_EN
    assign JALR = {jalr_sum[XLEN-1:1], 1'b0};
`else
    assign JALR = jalr_sum;
`endif

    // EX/MEM result register: reset > stall > flush > load
    always_ff @(posedge CLK) begin
        if (RST) begin
            RESULT_Q <= '0;
            FLAGS_Q  <= '0;
        end else if (EN) begin
            if (FLUSH) begin
                RESULT_Q <= '0;
                FLAGS_Q  <= '0;
            end else begin
                RESULT_Q <= RESULT;
                FLAGS_Q  <= {BR_LTU, BR_LT, BR_EQ};
            end
        end
    end

endmodule

// File: tb/tb_otter_ex_unit.sv
// Directed scoreboard bench for otter_ex_unit (both JALR builds).
module tb_otter_ex_unit;
    import otter_ex_pkg::*;

    localparam int unsigned W = 32;

    localparam int unsigned OBS_RESULT   = 0;
    localparam int unsigned OBS_JAL      = 1;
    localparam int unsigned OBS_BRANCH   = 2;
    localparam int unsigned OBS_JALR     = 3;
    localparam int unsigned OBS_RESULT_Q = 4;
    localparam int unsigned OBS_FLAGS_Q  = 5;
    localparam int unsigned OBS_FLAGS    = 6;

    typedef struct {
        string       tag;
        int unsigned what;
        logic [31:0] exp;
    } sb_item_t;

    logic         clk;
    logic         rst;
    logic         en;
    logic         flush;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic [3:0]   alu_fun;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic [W-1:0] pc;
    logic [W-1:0] i_type;
    logic [W-1:0] b_type;
    logic [W-1:0] j_type;
    logic [W-1:0] result;
    logic         br_eq;
    logic         br_lt;
    logic         br_ltu;
    logic [W-1:0] jal;
    logic [W-1:0] branch;
    logic [W-1:0] jalr;
    logic [W-1:0] result_q;
    logic [2:0]   flags_q;

    sb_item_t    sb_q[$];
    int unsigned checks = 0;
    int unsigned passed = 0;

    otter_ex_unit #(.XLEN(W)) dut (
        .CLK      (clk),
        .RST      (rst),
        .EN       (en),
        .FLUSH    (flush),
        .SRC_A    (src_a),
        .SRC_B    (src_b),
        .ALU_FUN  (alu_fun),
        .RS1      (rs1),
        .RS2      (rs2),
        .PC       (pc),
        .I_TYPE   (i_type),
        .B_TYPE   (b_type),
        .J_TYPE   (j_type),
        .RESULT   (result),
        .BR_EQ    (br_eq),
        .BR_LT    (br_lt),
        .BR_LTU   (br_ltu),
        .JAL      (jal),
        .BRANCH   (branch),
        .JALR     (jalr),
        .RESULT_Q (result_q),
        .FLAGS_Q  (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int unsigned what);
        case (what)
            OBS_RESULT:   return result;
            OBS_JAL:      return jal;
            OBS_BRANCH:   return branch;
            OBS_JALR:     return jalr;
            OBS_RESULT_Q: return result_q;
            OBS_FLAGS_Q:  return {29'd0, flags_q};
            OBS_FLAGS:    return {29'd0, br_ltu, br_lt, br_eq};
            default:      return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int unsigned what, input logic [31:0] exp);
        sb_item_t it;
        it.tag  = tag;
        it.what = what;
        it.exp  = exp;
        sb_q.push_back(it);
    endtask

    task automatic drain();
        sb_item_t    it;
        logic [31:0] obs;
        while (sb_q.size() != 0) begin
            it  = sb_q.pop_front();
            obs = observe(it.what);
            checks++;
            assert (obs === it.exp) passed++;
            else $error("FAIL %s: observed 0x%08h expected 0x%08h", it.tag, obs, it.exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_step(input string tag, input logic [3:0] fun, input logic [31:0] exp);
        alu_fun = fun;
        #1;
        expect_val(tag, OBS_RESULT, exp);
        drain();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0;
        src_a = '0; src_b = '0; alu_fun = 4'(ALU_ADD);
        rs1 = '0; rs2 = '0; pc = '0;
        i_type = '0; b_type = '0; j_type = '0;

        // Reset state
        edge_sample();
        expect_val("reset_result_q", OBS_RESULT_Q, 32'h0);
        expect_val("reset_flags_q", OBS_FLAGS_Q, 32'h0);
        drain();

        // ALU sweep with registers stalled
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        src_a = 32'h8000_0004; src_b = 32'h0000_0021;
        alu_step("alu_add",  4'(ALU_ADD),  32'h8000_0025);
        alu_step("alu_sub",  4'(ALU_SUB),  32'h7FFF_FFE3);
        alu_step("alu_sll",  4'(ALU_SLL),  32'h0000_0008);
        alu_step("alu_srl",  4'(ALU_SRL),  32'h4000_0002);
        alu_step("alu_sra",  4'(ALU_SRA),  32'hC000_0002);
        alu_step("alu_slt",  4'(ALU_SLT),  32'h0000_0001);
        alu_step("alu_sltu", 4'(ALU_SLTU), 32'h0000_0000);
        alu_step("alu_xor",  4'(ALU_XOR),  32'h8000_0025);
        alu_step("alu_or",   4'(ALU_OR),   32'h8000_0025);
        alu_step("alu_and",  4'(ALU_AND),  32'h0000_0000);
        alu_step("alu_lui",  4'(ALU_LUI),  32'h8000_0004);
        alu_step("alu_1111", 4'b1111,      32'h0000_0000);
        alu_step("alu_1010", 4'b1010,      32'h0000_0000);
        expect_val("stall_during_sweep", OBS_RESULT_Q, 32'h0);
        drain();

        // Branch condition generator
        rs1 = 32'hFFFF_FFFF; rs2 = 32'h1;
        #1;
        expect_val("bcg_neg_vs_one", OBS_FLAGS, 32'h2);
        drain();
        rs1 = 32'd5; rs2 = 32'd5;
        #1;
        expect_val("bcg_equal", OBS_FLAGS, 32'h1);
        drain();
        rs1 = 32'd1; rs2 = 32'hFFFF_FFFF;
        #1;
        expect_val("bcg_one_vs_neg", OBS_FLAGS, 32'h4);
        drain();

        // Branch address generator
        pc = 32'h100; j_type = 32'hFFFF_FFF0; b_type = 32'h20;
        rs1 = 32'h203; i_type = 32'd4;
        #1;
        expect_val("bag_jal", OBS_JAL, 32'h0000_00F0);
        expect_val("bag_branch", OBS_BRANCH, 32'h0000_0120);
`ifdef OTTER_JALR_LSB_CLEAR_EN
        expect_val("bag_jalr", OBS_JALR, 32'h0000_0206);
`else
        expect_val("bag_jalr", OBS_JALR, 32'h0000_0207);
`endif
        drain();
        pc = 32'hFFFF_FFF0; b_type = 32'h20;
        #1;
        expect_val("bag_branch_wrap", OBS_BRANCH, 32'h0000_0010);
        drain();

        // Register load then stall
        @(negedge clk);
        alu_fun = 4'(ALU_ADD); src_a = 32'd3; src_b = 32'd4;
        rs1 = 32'd5; rs2 = 32'd5; en = 1'b1;
        edge_sample();
        expect_val("load_result_q", OBS_RESULT_Q, 32'd7);
        expect_val("load_flags_q", OBS_FLAGS_Q, 32'h1);
        drain();
        @(negedge clk);
        en = 1'b0; src_a = 32'd100; rs1 = 32'hFFFF_FFFF; rs2 = 32'd1;
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            expect_val("stall_result_q", OBS_RESULT_Q, 32'd7);
            expect_val("stall_flags_q", OBS_FLAGS_Q, 32'h1);
            drain();
        end

        // Flush loads zero; flush ignored while stalled
        @(negedge clk);
        en = 1'b1; flush = 1'b1; src_a = 32'd3; src_b = 32'd4;
        edge_sample();
        expect_val("flush_result_q", OBS_RESULT_Q, 32'd0);
        expect_val("flush_flags_q", OBS_FLAGS_Q, 32'h0);
        drain();
        @(negedge clk);
        flush = 1'b0;
        edge_sample();
        expect_val("reload_result_q", OBS_RESULT_Q, 32'd7);
        expect_val("reload_flags_q", OBS_FLAGS_Q, 32'h2);
        drain();
        @(negedge clk);
        en = 1'b0; flush = 1'b1; src_a = 32'd50;
        edge_sample();
        expect_val("flush_stalled_result_q", OBS_RESULT_Q, 32'd7);
        expect_val("flush_stalled_flags_q", OBS_FLAGS_Q, 32'h2);
        drain();

        // Reset wins over enable; combinational path still live
        @(negedge clk);
        flush = 1'b0; en = 1'b1; rst = 1'b1; src_a = 32'd3; src_b = 32'd4;
        edge_sample();
        expect_val("rst_en_result_q", OBS_RESULT_Q, 32'd0);
        expect_val("rst_en_flags_q", OBS_FLAGS_Q, 32'h0);
        expect_val("rst_comb_result", OBS_RESULT, 32'd7);
        expect_val("rst_comb_flags", OBS_FLAGS, 32'h2);
        drain();

        // Reset during stall, then fresh capture
        @(negedge clk);
        rst = 1'b0;
        edge_sample();
        expect_val("post_rst_load", OBS_RESULT_Q, 32'd7);
        drain();
        @(negedge clk);
        en = 1'b0; rst = 1'b1;
        edge_sample();
        expect_val("rst_stall_result_q", OBS_RESULT_Q, 32'd0);
        expect_val("rst_stall_flags_q", OBS_FLAGS_Q, 32'h0);
        drain();
        @(negedge clk);
        rst = 1'b0; en = 1'b1; src_a = 32'd10; src_b = 32'd4; rs1 = 32'd9; rs2 = 32'd2;
        edge_sample();
        expect_val("fresh_result_q", OBS_RESULT_Q, 32'd14);
        expect_val("fresh_flags_q", OBS_FLAGS_Q, 32'h0);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/otter_ex_unit.md
Name: otter_ex_unit

Overview:
- Execute-stage arithmetic block of the pipelined OTTER RV32I core.
- Contains three parts: the ALU, the branch address generator (BAG) and the branch condition generator (BCG).
- All three produce results combinationally from already-forwarded operands.
- The ALU result and the three compare flags are also captured in an output register. That register is the alu_result field of the EX/MEM pipeline stage and has a hold (stall) input and a flush input.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  register enable; 0 holds the registered outputs (pipeline stall).
- FLUSH  in  1  when EN=1, loads zeros into the registered outputs instead of new results.
- SRC_A  in  32  ALU operand A (RS1 or U-immediate, selected upstream).
- SRC_B  in  32  ALU operand B (RS2, immediate or PC, selected upstream).
- ALU_FUN  in  4  ALU operation code.
- RS1  in  32  forwarded rs1 value; feeds BCG and JALR target.
- RS2  in  32  forwarded rs2 value; feeds BCG.
- PC  in  32  PC of the instruction in execute.
- I_TYPE  in  32  sign-extended I immediate.
- B_TYPE  in  32  sign-extended B immediate.
- J_TYPE  in  32  sign-extended J immediate.
- RESULT  out  32  combinational ALU result.
- BR_EQ  out  1  combinational: RS1 == RS2.
- BR_LT  out  1  combinational: RS1 < RS2, signed.
- BR_LTU  out  1  combinational: RS1 < RS2, unsigned.
- JAL  out  32  combinational: PC + J_TYPE.
- BRANCH  out  32  combinational: PC + B_TYPE.
- JALR  out  32  combinational: RS1 + I_TYPE (see Optional Feature).
- RESULT_Q  out  32  registered RESULT.
- FLAGS_Q  out  3  registered {BR_LTU, BR_LT, BR_EQ}.

Behaviour:
- ALU_FUN encoding:
  - 0000 ADD: A+B.
  - 1000 SUB: A-B.
  - 0001 SLL: A << B[4:0].
  - 0010 SLT: signed A<B, result 1 or 0.
  - 0011 SLTU: unsigned A<B, result 1 or 0.
  - 0100 XOR.
  - 0101 SRL: logical A >> B[4:0].
  - 1101 SRA: arithmetic A >>> B[4:0].
  - 0110 OR.
  - 0111 AND.
  - 1001 LUI-COPY: result = A.
  - All other codes: result 0.
- Arithmetic wraps modulo 2^32. No overflow or carry outputs.
- Shift amount uses B[4:0] only; B[31:5] is ignored.
- SLT/SLTU results are zero-extended to 32 bits.
- BAG sums wrap modulo 2^32. Immediates are already sign-extended and are added as-is, with no extra shift.
- All combinational outputs settle in the same cycle as the inputs (zero latency).
- Registered outputs, updated on the rising edge of CLK, in priority order:
  - RST=1: RESULT_Q=0, FLAGS_Q=0. Reset wins over all other inputs.
  - else EN=0: hold the current value. FLUSH is ignored while EN=0.
  - else FLUSH=1: load 0.
  - else: RESULT_Q<=RESULT, FLAGS_Q<={BR_LTU,BR_LT,BR_EQ}.
- Reset asserted mid-stall clears the registers on the next edge. After reset deasserts, the next EN=1 edge captures fresh data.
- There is no internal state apart from RESULT_Q and FLAGS_Q.

Optional Feature:
- Macro: OTTER_JALR_LSB_CLEAR_EN.
- Defined: JALR = (RS1 + I_TYPE) with bit 0 forced to 0, as required by the RISC-V spec.
- Undefined: JALR is the raw sum RS1 + I_TYPE, bit 0 unchanged.
- All other behaviour is identical in both builds.

Decomposition:
- Package otter_ex_pkg:
  - alu_fun_t, a 4-bit enum holding the codes above (ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI).
  - XLEN constant.
- One natural sub-module: otter_ex_alu, the pure combinational ALU case statement.
- BAG, BCG and the output register are kept inline in otter_ex_unit.

Test Plan:
1. ALU sweep, SRC_A=0x8000_0004, SRC_B=0x0000_0021:
   - ADD -> 0x8000_0025; SUB -> 0x7FFF_FFE3.
   - SLL -> 0x0000_0008 (shift amount 1).
   - SRL -> 0x4000_0002; SRA -> 0xC000_0002.
   - SLT -> 1; SLTU -> 0.
   - LUI-COPY -> 0x8000_0004; code 1111 -> 0.
2. BCG with RS1=0xFFFF_FFFF, RS2=1 -> BR_EQ=0, BR_LT=1, BR_LTU=0. With RS1=RS2=5 -> BR_EQ=1, BR_LT=0, BR_LTU=0.
3. BAG with PC=0x100, J_TYPE=0xFFFF_FFF0, B_TYPE=0x20, RS1=0x203, I_TYPE=4:
   - JAL=0xF0, BRANCH=0x120.
   - JALR=0x206 with the macro defined, 0x207 without.
4. Register timing: ADD 3+4, EN=1 -> RESULT_Q=7 after one edge. Then set EN=0 and change operands -> RESULT_Q stays 7 across 3 edges.
5. Flush: EN=1, FLUSH=1 with ADD 3+4 -> RESULT_Q=0, FLAGS_Q=0. EN=0 with FLUSH=1 -> RESULT_Q holds its previous value.
6. Reset: RST=1 together with EN=1 and valid operands -> RESULT_Q=0, FLAGS_Q=0 on the next edge. Combinational outputs keep tracking their inputs during reset.
